// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/shift ops and iterative radix-2 multiply/divide.
// Valid/ready on both sides; the result is held until the consumer takes it.
module alu_muldiv #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SHAMT_LSB = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUConf,
    input  logic             Sign,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi
);
    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MUL  = 3'd1;
    localparam logic [2:0] DIV  = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] HOLD = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             mul_q, mul_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             dz_q, dz_d;

    logic               accept, is_mul, is_div, slt;
    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   alu_res, mag1, mag2;
    logic [WIDTH:0]     add_sum, div_shift, sub_diff;
    logic [2*WIDTH-1:0] prod;

    assign in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (ALUConf == 5'b11010);
    assign is_div    = (ALUConf == 5'b11011);
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign ResultHi  = result_hi_q;

    always_comb begin
        shamt = In1[SHAMT_LSB +: SW];
        slt   = Sign ? ($signed(In1) < $signed(In2)) : (In1 < In2);
        case (ALUConf)
            5'b00000: alu_res = In1 + In2;
            5'b00001: alu_res = In1 | In2;
            5'b00010: alu_res = In1 & In2;
            5'b00110: alu_res = In1 - In2;
            5'b00111: alu_res = {{(WIDTH-1){1'b0}}, slt};
            5'b01100: alu_res = ~(In1 | In2);
            5'b01101: alu_res = In1 ^ In2;
            5'b10000: alu_res = In2 >> shamt;
            5'b11000: alu_res = $signed(In2) >>> shamt;
            5'b11001: alu_res = In2 << shamt;
            default:  alu_res = '0;
        endcase
    end

    // The iterative engine works on magnitudes; signs are reapplied in FIX.
    always_comb begin
        mag1 = In1;
        mag2 = In2;
        if (Sign && In1[WIDTH-1]) mag1 = '0 - In1;
        if (Sign && In2[WIDTH-1]) mag2 = '0 - In2;
        add_sum   = sh_q[0] ? acc_q + {1'b0, opd_q} : acc_q;
        div_shift = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
        sub_diff  = div_shift - {1'b0, opd_q};
        prod      = {acc_q[WIDTH-1:0], sh_q};
        if (neg_lo_q) prod = '0 - prod;
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        acc_d       = acc_q;
        sh_d        = sh_q;
        opd_d       = opd_q;
        cnt_d       = cnt_q;
        mul_d       = mul_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        dz_d        = dz_q;
        case (state_q)
            MUL: begin
                acc_d = add_sum >> 1;
                sh_d  = {add_sum[0], sh_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SW'(WIDTH - 1)) state_d = FIX;
            end
            DIV: begin
                if (sub_diff[WIDTH]) begin
                    acc_d = div_shift;
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = sub_diff;
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (mul_q) begin
                    result_d    = prod[WIDTH-1:0];
                    result_hi_d = prod[2*WIDTH-1:WIDTH];
                end else begin
                    result_d    = dz_q ? '1 : (neg_lo_q ? '0 - sh_q : sh_q);
                    result_hi_d = neg_hi_q ? '0 - acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            default: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                if (accept) begin
                    if (is_mul || is_div) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        sh_d        = is_mul ? mag2 : mag1;
                        opd_d       = is_mul ? mag1 : mag2;
                        cnt_d       = '0;
                        mul_d       = is_mul;
                        neg_lo_d    = Sign && (In1[WIDTH-1] ^ In2[WIDTH-1]);
                        neg_hi_d    = Sign && In1[WIDTH-1];
                        dz_d        = is_div && (In2 == '0);
                        state_d     = is_mul ? MUL : DIV;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            acc_q       <= '0;
            sh_q        <= '0;
            opd_q       <= '0;
            cnt_q       <= '0;
            mul_q       <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            acc_q       <= acc_d;
            sh_q        <= sh_d;
            opd_q       <= opd_d;
            cnt_q       <= cnt_d;
            mul_q       <= mul_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            dz_q        <= dz_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_alu_muldiv;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, Sign, out_valid, out_ready;
    logic [4:0]   ALUConf;
    logic [W-1:0] In1, In2, Result, ResultHi;

    typedef struct {
        logic [63:0] val;
        int unsigned acc;
        int unsigned due;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          rnd_rdy = 1'b0;
    logic [4:0]  ops [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111, 5'b01100,
                              5'b01101, 5'b10000, 5'b11000, 5'b11001, 5'b11010, 5'b11011};

    alu_muldiv #(.WIDTH(W), .SHAMT_LSB(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUConf(ALUConf), .Sign(Sign), .In1(In1), .In2(In2),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .ResultHi(ResultHi)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: returns {hi, lo}
    function automatic logic [63:0] model(input logic [4:0] c, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] lo;
        longint      sa, sb;
        int          si1, si2, qi, ri;
        sh = a[10:6];
        lo = '0;
        case (c)
            5'b00000: lo = a + b;
            5'b00001: lo = a | b;
            5'b00010: lo = a & b;
            5'b00110: lo = a - b;
            5'b00111: lo = s ? 32'($signed(a) < $signed(b)) : 32'(a < b);
            5'b01100: lo = ~(a | b);
            5'b01101: lo = a ^ b;
            5'b10000: lo = b >> sh;
            5'b11000: lo = $signed(b) >>> sh;
            5'b11001: lo = b << sh;
            5'b11010: begin
                if (s) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    return 64'(sa * sb);
                end
                return {32'b0, a} * {32'b0, b};
            end
            5'b11011: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (s) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                    si1 = $signed(a);
                    si2 = $signed(b);
                    qi  = si1 / si2;
                    ri  = si1 % si2;
                    return {32'(ri), 32'(qi)};
                end
                return {a % b, a / b};
            end
            default: lo = '0;
        endcase
        return {32'd0, lo};
    endfunction

    function automatic logic [31:0] rnd_opd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Presents an op (called at posedge+1) and returns at posedge+1 after the accept edge.
    task automatic issue(input logic [4:0] c, input logic s, input logic [31:0] a, input logic [31:0] b);
        int unsigned n;
        bit          done;
        exp_t        e;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        ALUConf = c;
        Sign = s;
        In1 = a;
        In2 = b;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.val = model(c, s, a, b);
                e.acc = cyc + 1;
                e.due = (c == 5'b11010 || c == 5'b11011) ? cyc + 1 + W + 1 : cyc + 1;
                q.push_back(e);
                done = 1'b1;
            end else if (++n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", n);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        ALUConf = 5'($urandom);
        Sign = 1'($urandom);
        In1 = $urandom;
        In2 = $urandom;
    endtask

    // Monitor: compares each presented result with the scoreboard head.
    initial begin
        bit          cur_active;
        bit          busy;
        logic [63:0] held;
        exp_t        e;
        cur_active = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cur_active = 1'b0;
                q.delete();
            end else begin
                if (cur_active) check("valid_held", 64'(out_valid), 64'd1);
                if (out_valid) begin
                    if (!cur_active) begin
                        if (q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_valid: got out_valid=1 with no op pending, required 0");
                        end else begin
                            e = q[0];
                            check("latency", 64'(cyc), 64'(e.due));
                            check("result", 64'(Result), 64'(e.val[31:0]));
                            check("result_hi", 64'(ResultHi), 64'(e.val[63:32]));
                        end
                        cur_active = 1'b1;
                        held = {ResultHi, Result};
                    end else begin
                        check("hold_stable", {ResultHi, Result}, held);
                    end
                    check("in_ready_hold", 64'(in_ready), 64'(out_ready));
                    if (out_ready) begin
                        cur_active = 1'b0;
                        if (q.size() > 0) void'(q.pop_front());
                    end
                end else begin
                    busy = 1'b0;
                    foreach (q[i])
                        if (q[i].due > q[i].acc && cyc >= q[i].acc && cyc < q[i].due) busy = 1'b1;
                    check("in_ready_idle", 64'(in_ready), 64'(!busy));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ALUConf = '0;
        Sign = 1'b0;
        In1 = '0;
        In2 = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(Result), 64'd0);
        check("rst_result_hi", 64'(ResultHi), 64'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;

        issue(5'b00111, 1'b1, 32'd5, 32'hFFFF_FFFD);
        issue(5'b00111, 1'b0, 32'd5, 32'hFFFF_FFFD);
        issue(5'b11010, 1'b1, 32'hFFFF_FFF9, 32'd6);
        issue(5'b11011, 1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(5'b11011, 1'b0, 32'd9, 32'd0);
        issue(5'b11011, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'b11011, 1'b1, 32'hFFFF_FFF7, 32'd0);
        issue(5'b11010, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(5'b11000, 1'b0, 32'd31 << 6, 32'h8000_0010);
        issue(5'b10000, 1'b0, 32'd4 << 6, 32'h8000_0010);
        issue(5'b11001, 1'b0, 32'd31 << 6, 32'h0000_0003);
        issue(5'b11111, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (3) tick();

        // Result held with no consumer while another op waits at the input
        out_ready = 1'b0;
        issue(5'b00000, 1'b0, 32'hFFFF_FFFF, 32'd2);
        in_valid = 1'b1;
        ALUConf = 5'b00110;
        Sign = 1'b1;
        In1 = 32'd3;
        In2 = 32'd10;
        repeat (6) tick();
        out_ready = 1'b1;
        issue(5'b00110, 1'b1, 32'd3, 32'd10);
        repeat (3) tick();

        // Abort a divide with reset
        issue(5'b11011, 1'b0, 32'd100, 32'd7);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result", 64'(Result), 64'd0);
        check("abort_result_hi", 64'(ResultHi), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (40) tick();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [4:0] c;
            c = ($urandom_range(0, 4) == 0) ? 5'($urandom) : ops[$urandom_range(0, 11)];
            issue(c, 1'($urandom), rnd_opd(), rnd_opd());
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 200 && q.size() != 0; n++) tick();
        tick();
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: datapath width; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHAMT_LSB, default 6: lowest bit of the shift-amount field in In1; the field is clog2(WIDTH) bits wide.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: an operation is presented.
REQ-006 Port in_ready, output, 1 bit: an operation is accepted on a cycle with in_valid && in_ready.
REQ-007 Port ALUConf, input, 5 bits: operation select.
REQ-008 Port Sign, input, 1 bit: signed (1) or unsigned (0) interpretation.
REQ-009 Ports In1 and In2, input, WIDTH bits each: operands.
REQ-010 Port out_valid, output, 1 bit: Result and ResultHi are valid.
REQ-011 Port out_ready, input, 1 bit: the consumer takes the result on a cycle with out_valid && out_ready.
REQ-012 Port Result, output, WIDTH bits: primary result (low product or quotient).
REQ-013 Port ResultHi, output, WIDTH bits: high product or remainder; 0 for single-cycle ops.

Function
REQ-014 Single-cycle ops are encoded as follows:
- 00000 add; 00001 or; 00010 and; 00110 sub
- 00111 set-less-than (signed if Sign, else unsigned; zero-extended 1-bit result)
- 01100 nor; 01101 xor
- 10000 logical right shift of In2; 11000 arithmetic right shift of In2; 11001 left shift of In2
- all three shifts use the shamt field of In1
REQ-015 Multi-cycle ops are encoded as follows:
- 11010 multiply: full 2*WIDTH product; {ResultHi,Result} = product
- 11011 divide: Result = quotient, ResultHi = remainder
REQ-016 Any other ALUConf value shall produce Result=0 and ResultHi=0 with single-cycle timing.
REQ-017 Arithmetic shall wrap modulo 2^WIDTH with no overflow flag.
REQ-018 The FSM states shall be IDLE, MUL, DIV, FIX and HOLD.
REQ-019 IDLE: in_ready = 1 when !out_valid || out_ready, so a new operation may be accepted on the same cycle the previous result is consumed.
REQ-020 A single-cycle op accepted at edge k shall drive its result with out_valid=1 in the cycle after edge k (latency 1), then enter HOLD.
REQ-021 MUL and DIV shall process operand magnitudes with a radix-2 shift-add / restoring-subtract loop, one bit per cycle, for exactly WIDTH cycles.
REQ-022 After the loop, FIX shall apply the sign correction for one cycle, then enter HOLD with out_valid=1.
REQ-023 Multi-cycle latency from the accept edge to out_valid shall be exactly WIDTH+1 cycles.
REQ-024 Sign rules for signed operations:
- product sign = sign(In1) XOR sign(In2)
- quotient truncates toward zero
- remainder takes the sign of the dividend
REQ-025 Divide by zero (In2 == 0): Result = all ones, ResultHi = In1, same latency as a normal divide.
REQ-026 Signed overflow (In1 = MIN, In2 = -1): Result = MIN, ResultHi = 0.
REQ-027 in_ready shall be 0 throughout MUL, DIV and FIX; in_valid during those states is ignored.
REQ-028 HOLD: Result, ResultHi and out_valid shall stay stable until out_valid && out_ready; the state then returns to IDLE, or accepts the next operation on that same edge.
REQ-029 Operands and ALUConf shall be registered at acceptance; input changes after the accept edge shall not affect the result.

Reset
REQ-030 While reset = 1 at a clock edge:
- state goes to IDLE
- out_valid = 0; Result = 0; ResultHi = 0
- internal counter and accumulators cleared
REQ-031 Reset mid-operation shall abort the operation with no result emitted; in_ready = 1 on the first cycle after reset deasserts.

Verification
REQ-032 Scenario: In1=5, In2=-3, ALUConf=00111, Sign=1 -> Result=0 after 1 cycle; the same with Sign=0 -> Result=1.
REQ-033 Scenario: multiply, Sign=1, In1=-7, In2=6 -> after 33 cycles {ResultHi,Result} = 0xFFFFFFFF_FFFFFFD6; in_ready stays 0 while the op runs.
REQ-034 Scenario: divide, Sign=1, In1=-7, In2=2 -> Result = -3, ResultHi = -1.
REQ-035 Scenario: divide by zero, In1=9 -> Result = 0xFFFFFFFF, ResultHi = 9.
REQ-036 Scenario: divide, Sign=1, In1 = 0x80000000, In2 = -1 -> Result = 0x80000000, ResultHi = 0.
REQ-037 Scenario: out_ready held 0 for 5 cycles -> result stable with no new accept; then reset asserted mid-divide -> out_valid = 0 and in_ready = 1 on the next cycle after reset deasserts.
